// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, per-register control bundle, watchdog width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int WCNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    // Load enables and bubble-insert flushes for the PC and every pipeline register
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctl_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination feeds a source operand of the instruction in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the top decides whether the hazard is acted upon.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    // x0 is never a real dependency, so a load targeting it cannot create a hazard
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
            load_use = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, EX redirect, slow dmem, watchdog halt); PIPE_CTRL_PERF_EN adds perf counters.
// Latency: controls are combinational from inputs and registered state; state/counters update on clk rise.
// Backpressure: dmem not ready stalls everything upstream of MEM/WB; a watchdog expiry freezes the pipe until reset.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [WCNT_W-1:0] TIMEOUT_W = WCNT_W'(TIMEOUT_CYCLES);

    pipe_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;

    logic      load_use;
    logic      mem_stall;
    pipe_ctl_t ctl;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // Hazard priority: memory stall, then redirect (load-use consumer is on the wrong path), then load-use
    always_comb begin
        ctl       = '0;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        if (!reset && (state_q != HALT)) begin
            dmem_req  = mem_access;
            mem_stall = mem_access & ~dmem_ready;
            if (mem_stall) begin
                // MEM/WB takes a bubble each stalled cycle so the held instruction writes back only once
                ctl.mem_wb_en    = 1'b1;
                ctl.mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                ctl.pc_en       = 1'b1;
                ctl.if_id_en    = 1'b1;
                ctl.id_ex_en    = 1'b1;
                ctl.ex_mem_en   = 1'b1;
                ctl.mem_wb_en   = 1'b1;
                ctl.if_id_flush = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end else if (load_use) begin
                ctl.id_ex_en    = 1'b1;
                ctl.ex_mem_en   = 1'b1;
                ctl.mem_wb_en   = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end else begin
                ctl.pc_en     = 1'b1;
                ctl.if_id_en  = 1'b1;
                ctl.id_ex_en  = 1'b1;
                ctl.ex_mem_en = 1'b1;
                ctl.mem_wb_en = 1'b1;
            end
        end
    end

    assign pc_en        = ctl.pc_en;
    assign if_id_en     = ctl.if_id_en;
    assign id_ex_en     = ctl.id_ex_en;
    assign ex_mem_en    = ctl.ex_mem_en;
    assign mem_wb_en    = ctl.mem_wb_en;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_flush = ctl.ex_mem_flush;
    assign mem_wb_flush = ctl.mem_wb_flush;
    assign mem_err      = mem_err_q;

    // Next state and watchdog: wcnt counts consecutive stalled cycles, halting once it has reached the limit
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Leaving on !mem_stall also covers a dropped request, which would otherwise wait forever
                if (!mem_stall) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == TIMEOUT_W) begin
                    state_d   = HALT;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // State register, watchdog counter and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Stalled = PC held outside reset/HALT; a flush event is a redirect cycle, the only source of if_id_flush
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!reset && (state_q != HALT) && !ctl.pc_en) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ctl.if_id_flush) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    // Performance counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected controls, a negedge monitor pops and compares.
// Latency: expected values apply in the same cycle the inputs are driven.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_LU   = 5'b00111;
    localparam logic [4:0] EN_MS   = 5'b00001;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [3:0] FL_NONE = 4'b0000;
    localparam logic [3:0] FL_LU   = 4'b0100;
    localparam logic [3:0] FL_RD   = 4'b1100;
    localparam logic [3:0] FL_MS   = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_redirect, mem_access, dmem_ready;
    logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
    logic [31:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    typedef struct {
        int          id;
        logic [4:0]  en;
        logic [3:0]  fl;
        logic        req;
        logic        err;
        logic        chk_perf;
        logic [31:0] st;
        logic [31:0] fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    logic        perf_chk = 1'b0;
    logic [31:0] perf_st  = '0;
    logic [31:0] perf_fe  = '0;

    // Arm a counter check on the next vector
    task automatic expect_perf(input logic [31:0] st, input logic [31:0] fe);
        perf_chk = 1'b1;
        perf_st  = st;
        perf_fe  = fe;
    endtask

    // Apply one cycle of inputs just after the rising edge and queue the hand-computed response
    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic redir,
                        input logic ma, input logic rdy,
                        input logic [4:0] en, input logic [3:0] fl, input logic req, input logic err);
        exp_t x;
        @(posedge clk);
        #1;
        reset       = rst;
        id_rs1      = rs1;
        id_rs2      = rs2;
        ex_mem_read = mr;
        ex_rd       = rd;
        ex_redirect = redir;
        mem_access  = ma;
        dmem_ready  = rdy;
        x.id       = vec_id;
        x.en       = en;
        x.fl       = fl;
        x.req      = req;
        x.err      = err;
        x.chk_perf = perf_chk;
        x.st       = perf_st;
        x.fe       = perf_fe;
        exp_q.push_back(x);
        vec_id   = vec_id + 1;
        perf_chk = 1'b0;
    endtask

    // Monitor: the controls are valid every cycle, so one queued expectation is consumed per falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== e.en ||
                {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} !== e.fl ||
                dmem_req !== e.req || mem_err !== e.err) begin
                n_fail++;
                $display("FAIL ctl vec %0d: got en=%b fl=%b req=%b err=%b, want en=%b fl=%b req=%b err=%b",
                         e.id, {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                         {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, dmem_req, mem_err,
                         e.en, e.fl, e.req, e.err);
            end
            if (e.chk_perf) begin
                n_tests++;
                if (stall_cycles !== e.st || flush_events !== e.fe) begin
                    n_fail++;
                    $display("FAIL perf vec %0d: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                             e.id, stall_cycles, flush_events, e.st, e.fe);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_mem_read = 1'b0; ex_rd = '0;
        ex_redirect = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;

        // Reset: everything forced low even with a pending memory access
        expect_perf(0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NONE, 0, 0);
        step(1, 5, 5, 1, 5, 1, 1, 0, EN_NONE, FL_NONE, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0);

        // Load-use on rs1 for one cycle, then the bubble has advanced
        step(0, 5, 0, 1, 5, 0, 0, 0, EN_LU,   FL_LU,   0, 0);
        step(0, 5, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0);
        // Load into x0 is never a hazard
        step(0, 0, 0, 1, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0);
        // Load-use on rs2
        step(0, 3, 7, 1, 7, 0, 0, 0, EN_LU,   FL_LU,   0, 0);
        // Redirect overrides a load-use match
        step(0, 9, 0, 1, 9, 1, 0, 0, EN_ALL,  FL_RD,   0, 0);
        // Single-cycle memory: request but no stall
        step(0, 0, 0, 0, 0, 0, 1, 1, EN_ALL,  FL_NONE, 1, 0);
        // Three-cycle memory wait; redirect and load-use deferred while stalled
        step(0, 0, 0, 0, 0, 0, 1, 0, EN_MS,   FL_MS,   1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, EN_MS,   FL_MS,   1, 0);
        step(0, 4, 0, 1, 4, 0, 1, 0, EN_MS,   FL_MS,   1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, EN_ALL,  FL_NONE, 1, 0);
        expect_perf(PERF ? 32'd5 : 32'd0, PERF ? 32'd1 : 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0);
        // dmem_ready without a request is ignored; redirect alone
        step(0, 0, 0, 0, 0, 1, 0, 1, EN_ALL,  FL_RD,   0, 0);

        // Reset pulse in the middle of a memory wait
        step(0, 0, 0, 0, 0, 0, 1, 0, EN_MS,   FL_MS,   1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, EN_MS,   FL_MS,   1, 0);
        expect_perf(0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NONE, 0, 0);
        expect_perf(0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, EN_MS,   FL_MS,   1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, EN_ALL,  FL_NONE, 1, 0);

        // Watchdog with limit 4: one RUN stall cycle plus four MEM_WAIT cycles, then HALT
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0, EN_MS, FL_MS, 1, 0);
        end
        step(0, 0, 0, 0, 0, 0, 1, 1, EN_NONE, FL_NONE, 0, 1);
        step(0, 6, 0, 1, 6, 1, 1, 0, EN_NONE, FL_NONE, 0, 1);
        expect_perf(PERF ? 32'd6 : 32'd0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, EN_NONE, FL_NONE, 0, 1);

        // Only reset leaves HALT
        expect_perf(0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, EN_NONE, FL_NONE, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, EN_ALL,  FL_NONE, 1, 0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. It generates per-register enable and flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources: load-use, taken branch/jump in EX, and multi-cycle data-memory access in MEM. A wait-cycle watchdog halts the pipeline with a sticky error if data memory never responds.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum MEM_WAIT cycles before the error halt; legal range 1..65535.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `mem_access`  in  1  instruction in MEM is a load or store.
- `dmem_ready`  in  1  data memory completes the current access this cycle.
- `dmem_req`  out  1  data-memory request strobe.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  load a bubble (all fields zero) instead of the input.
- `mem_err`  out  1  sticky watchdog error.
- `stall_cycles`  out  32  performance counter.
- `flush_events`  out  32  performance counter.

## Operation
- Register state has three values: RUN, MEM_WAIT, HALT. There is a 16-bit wait counter `wcnt`.
- `dmem_req` = `mem_access` in RUN or MEM_WAIT; 0 in HALT.
- Memory stall (`mem_stall`) = `dmem_req & !dmem_ready`. While `mem_stall` is high:
  - `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0.
  - `mem_wb_en` is 1 and `mem_wb_flush` is 1, so no duplicate writeback occurs.
  - Redirect and load-use handling are deferred and re-evaluated once the stall clears.
- Redirect (no `mem_stall`, `ex_redirect`=1):
  - All enables are 1.
  - `if_id_flush` and `id_ex_flush` are 1.
  - Redirect has priority over load-use, because the load-use consumer is on the wrong path.
- Load-use (no `mem_stall`, no redirect): the condition is `ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
  - `pc_en` and `if_id_en` are 0.
  - `id_ex_flush` is 1.
  - All other enables are 1.
- Otherwise all enables are 1 and all flushes are 0. `ex_mem_flush` is always 0; it is reserved.
- State transitions:
  - RUN → MEM_WAIT on `mem_stall`, with `wcnt` set to 1.
  - MEM_WAIT → RUN on `dmem_ready`.
  - MEM_WAIT increments `wcnt` each stalled cycle. When `wcnt`==`TIMEOUT_CYCLES` while still stalled, the state goes to HALT and `mem_err` is set.
  - HALT freezes everything: all enables are 0, all flushes are 0, and `dmem_req` is 0. HALT exits only by reset.

## Timing
- All enable, flush and `dmem_req` outputs are combinational from inputs and registered state, with zero latency.
- A single-cycle memory (`dmem_ready` in the same cycle as the request) causes no stall.
- State and counters update on the rising edge of `clk`.
- While `reset` is high:
  - State is RUN, `wcnt`=0, `mem_err`=0, and both counters are 0.
  - All enables are forced to 0, all flushes to 0, and `dmem_req` to 0.
- Reset asserted mid-MEM_WAIT or mid-HALT aborts immediately. The pipeline resumes in RUN on the first edge after release.
- `dmem_ready` without `dmem_req` is ignored.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle where `pc_en`=0 outside reset/HALT.
  - `flush_events` increments on every redirect cycle.
  - Both counters wrap at 2^32.
- Not defined: both ports are tied to 0 and the counters are not instantiated.

## Structure
- `pipe_ctrl_pkg` holds:
  - The `pipe_state_e` enum (RUN, MEM_WAIT, HALT).
  - The `pipe_ctl_t` struct bundling the enable and flush bits per register.
  - The constant `WCNT_W`=16.
- One sub-module: `load_use_detect`, which is combinational and produces the load-use condition.
- The FSM, watchdog and counters live in the top module.

## Test plan
- `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5 → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 for exactly one cycle; repeat with `ex_rd`=0 → no stall.
- `ex_redirect`=1 together with a load-use match → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, no stall.
- `mem_access`=1, `dmem_ready` low for 3 cycles then high → 3 cycles with `pc_en`=0 and `mem_wb_flush`=1; state returns to RUN; `stall_cycles`=3 when `PIPE_CTRL_PERF_EN` is defined.
- `mem_access`=1 with `dmem_ready` held in the same cycle → no stall, state remains RUN.
- `TIMEOUT_CYCLES`=4, `dmem_ready` never asserted → HALT after 4 wait cycles, `mem_err`=1, `dmem_req`=0, all enables 0; remains so until reset.
- `reset` pulsed during MEM_WAIT → `mem_err`=0, counters 0, RUN after release, pipeline advances normally.
